// File: rtl/stopwatch_display.sv
// Up/down BCD stopwatch with tick prescaler, run/pause/expiry control,
// warning light and active-low seven-segment outputs.
module stopwatch_display #(
  parameter int TICK_DIV = 50000000,
  parameter int DIGITS   = 2,
  parameter int WARN     = 10,
  parameter bit BLANK    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start_stop,
  input  logic                mode,
  output logic [8*DIGITS-1:0] seg,
  output logic                light,
  output logic                done,
  output logic                running
);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int CW   = 4 * DIGITS;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int FULL = pow10(DIGITS);

  function automatic int bcd_to_int(input logic [CW-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b0000_0010;
      4'd1:    s = 8'b1001_1110;
      4'd2:    s = 8'b0010_0100;
      4'd3:    s = 8'b0000_1100;
      4'd4:    s = 8'b1001_1000;
      4'd5:    s = 8'b0100_1000;
      4'd6:    s = 8'b0100_0000;
      4'd7:    s = 8'b0001_1110;
      4'd8:    s = 8'b0000_0000;
      4'd9:    s = 8'b0001_1000;
      default: s = 8'b1111_1111;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          light_q, light_d;
  logic          done_q, done_d;
  logic          running_q, running_d;

  logic          tick;
  logic [CW-1:0] inc_val, dec_val, sat_val;
  logic          inc_wrap;
  logic          down_end;
  logic          in_win;
  int            tick_int;

  assign tick     = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign down_end = (count_q == '0) || (count_q == CW'(1));

  // Ripple BCD increment/decrement and load saturation, one digit per iteration.
  always_comb begin : bcd_arith
    logic carry, borrow;
    inc_val = count_q;
    dec_val = count_q;
    sat_val = load_val;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) sat_val[4*i +: 4] = 4'd9;
    end
    inc_wrap = carry;
  end

  // Window is judged on the count the tick would leave behind.
  always_comb begin
    tick_int = bcd_to_int(mode ? dec_val : inc_val);
    if (mode) in_win = (tick_int >= 1) && (tick_int <= WARN);
    else      in_win = (tick_int >= FULL - WARN);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    light_d = light_q;
    done_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      presc_d = '0;
      light_d = 1'b0;
      state_d = IDLE;
    end else if (load) begin
      count_d = sat_val;
      presc_d = '0;
      light_d = 1'b0;
      state_d = (state_q == RUN) ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          light_d = 1'b0;
          if (start_stop && !(mode && count_q == '0)) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            presc_d = '0;
            if (mode && down_end) begin
              count_d = '0;
              done_d  = 1'b1;
              light_d = 1'b1;
              state_d = EXPIRED;
            end else begin
              count_d = mode ? dec_val : inc_val;
              done_d  = !mode && inc_wrap;
              light_d = in_win ? ~light_q : 1'b0;
              if (start_stop) state_d = PAUSE;
            end
          end else if (start_stop) begin
            state_d = PAUSE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (start_stop) state_d = RUN;
        end
        EXPIRED: begin
          presc_d = '0;
          light_d = 1'b1;
          if (start_stop) begin
            state_d = IDLE;
            light_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      light_q   <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      light_q   <= light_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign light   = light_q;
  assign done    = done_q;
  assign running = running_q;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    logic blank;
    if (gi == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_msd
      assign blank = BLANK && (count_q[CW-1:4*gi] == '0);
    end
    assign seg[8*gi +: 8] = blank ? 8'hFF : seg_decode(count_q[4*gi +: 4]);
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench: driver runs an integer-level model and queues the expected
// outputs per clock; a monitor pops and compares after every rising edge.
module tb_stopwatch_display;

  localparam int TD   = 4;
  localparam int WARN = 10;
  localparam int FULL = 100;

  logic        clk;
  logic        rst;
  logic        clear, load, start_stop, mode;
  logic [7:0]  load_val;
  logic [15:0] seg_a, seg_b;
  logic        light_a, done_a, running_a;
  logic        light_b, done_b, running_b;

  stopwatch_display #(.TICK_DIV(TD), .DIGITS(2), .WARN(WARN), .BLANK(1'b0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .start_stop(start_stop), .mode(mode), .seg(seg_a), .light(light_a),
    .done(done_a), .running(running_a)
  );

  stopwatch_display #(.TICK_DIV(TD), .DIGITS(2), .WARN(WARN), .BLANK(1'b1)) u_blank (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .start_stop(start_stop), .mode(mode), .seg(seg_b), .light(light_b),
    .done(done_b), .running(running_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] seg;
    logic [15:0] seg_b;
    logic        light;
    logic        done;
    logic        running;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] seg_tbl [10] = '{8'b00000010, 8'b10011110, 8'b00100100, 8'b00001100,
                               8'b10011000, 8'b01001000, 8'b01000000, 8'b00011110,
                               8'b00000000, 8'b00011000};

  // Reference model state: count as a plain integer 0..99.
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  int m_cnt, m_pre, m_st;
  bit m_light, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] exp_seg(input int c, input bit blank);
    logic [15:0] s;
    s[7:0]  = seg_tbl[c % 10];
    s[15:8] = (blank && c < 10) ? 8'hFF : seg_tbl[(c / 10) % 10];
    return s;
  endfunction

  function automatic bit in_window(input int c, input bit md);
    if (md) return (c >= 1) && (c <= WARN);
    return c >= FULL - WARN;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_st = S_IDLE; m_light = 0; m_done = 0;
  endtask

  task automatic model_apply(input bit c, input bit l, input logic [7:0] lv,
                             input bit s, input bit md);
    int hi, lo;
    m_done = 0;
    if (c) begin
      m_cnt = 0; m_pre = 0; m_light = 0; m_st = S_IDLE;
    end else if (l) begin
      hi = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
      lo = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
      m_cnt = hi * 10 + lo; m_pre = 0; m_light = 0;
      m_st = (m_st == S_RUN) ? S_RUN : S_IDLE;
    end else begin
      case (m_st)
        S_IDLE:  if (s && !(md && m_cnt == 0)) m_st = S_RUN;
        S_RUN: begin
          if (m_pre == TD - 1) begin
            m_pre = 0;
            if (md && m_cnt <= 1) begin
              m_cnt = 0; m_done = 1; m_light = 1; m_st = S_EXP;
            end else begin
              if (md) m_cnt = m_cnt - 1;
              else begin
                m_done = (m_cnt == FULL - 1);
                m_cnt  = (m_cnt + 1) % FULL;
              end
              m_light = in_window(m_cnt, md) ? !m_light : 1'b0;
              if (s) m_st = S_PAUSE;
            end
          end else if (s) m_st = S_PAUSE;
          else m_pre = m_pre + 1;
        end
        S_PAUSE: if (s) m_st = S_RUN;
        default: if (s) begin m_st = S_IDLE; m_light = 0; end
      endcase
    end
  endtask

  task automatic step(input bit c, input bit l, input logic [7:0] lv,
                      input bit s, input bit md);
    exp_t e;
    @(negedge clk);
    clear = c; load = l; load_val = lv; start_stop = s; mode = md;
    model_apply(c, l, lv, s, md);
    e.seg = exp_seg(m_cnt, 0); e.seg_b = exp_seg(m_cnt, 1);
    e.light = m_light; e.done = m_done; e.running = (m_st == S_RUN); e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit md);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, md);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, 32'(seg_a), 32'h0202);
    chk({tag, "_seg_blank"}, 32'(seg_b), 32'hFF02);
    chk({tag, "_light"}, 32'(light_a), 0);
    chk({tag, "_done"}, 32'(done_a), 0);
    chk({tag, "_running"}, 32'(running_a), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("seg(cnt=%0d)", e.cnt), 32'(seg_a), 32'(e.seg));
        chk($sformatf("seg_blank(cnt=%0d)", e.cnt), 32'(seg_b), 32'(e.seg_b));
        chk($sformatf("light(cnt=%0d)", e.cnt), 32'(light_a), 32'(e.light));
        chk($sformatf("done(cnt=%0d)", e.cnt), 32'(done_a), 32'(e.done));
        chk($sformatf("running(cnt=%0d)", e.cnt), 32'(running_a), 32'(e.running));
      end
    end
  end

  initial begin : driver
    bit cur_mode;
    rst = 1'b0; clear = 0; load = 0; start_stop = 0; mode = 0; load_val = 8'h00;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Up mode from 00, then run through 89..99 -> 00 wrap with the warning light.
    step(0, 0, 8'h00, 1, 0);
    idle(10, 0);
    step(0, 1, 8'h88, 0, 0);
    idle(4 * 15, 0);

    // Down from 03 to expiry, then back to IDLE.
    step(1, 0, 8'h00, 0, 1);
    step(0, 1, 8'h03, 0, 1);
    step(0, 0, 8'h00, 1, 1);
    idle(4 * 4 + 3, 1);
    step(0, 0, 8'h00, 1, 1);
    idle(3, 1);

    // Pause with prescaler at 2, resume.
    step(1, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    idle(2, 0);
    step(0, 0, 8'h00, 1, 0);
    idle(20, 0);
    step(0, 0, 8'h00, 1, 0);
    idle(8, 0);

    // Priority and load saturation, then blanking of a leading zero.
    step(1, 1, 8'h45, 1, 0);
    idle(2, 0);
    step(0, 1, 8'hAF, 0, 0);
    idle(2, 0);
    step(0, 1, 8'h05, 0, 0);
    idle(2, 0);

    // Asynchronous reset while running at 57.
    step(0, 1, 8'h56, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    idle(5, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    cur_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) cur_mode = !cur_mode;
      step($urandom_range(199) < 2, $urandom_range(99) < 3, 8'($urandom),
           $urandom_range(99) < 6, cur_mode);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
